// File: rtl/game_round_controller_pkg.sv
// Shared definitions for the game blocks: phase encoding used on the State output.
package game_pkg;

  typedef enum logic [1:0] {
    GS_IDLE         = 2'd0,
    GS_PLAYING      = 2'd1,
    GS_PAUSED       = 2'd2,
    GS_INTERMISSION = 2'd3
  } game_state_t;

endpackage

// File: rtl/game_round_controller_if.sv
// Button/time-base inputs and phase/countdown outputs of the round controller.
interface game_round_controller_if #(
  parameter int TIME_W  = 8,
  parameter int ROUND_W = 2
);
  logic               StartGame;
  logic               PauseGame;
  logic               Tick;
  logic [1:0]         State;
  logic [TIME_W-1:0]  TimeLeft;
  logic [ROUND_W-1:0] Round;
  logic               RoundDone;
  logic               GameDone;

  modport master (
    output StartGame, PauseGame, Tick,
    input  State, TimeLeft, Round, RoundDone, GameDone
  );

  modport slave (
    input  StartGame, PauseGame, Tick,
    output State, TimeLeft, Round, RoundDone, GameDone
  );
endinterface

// File: rtl/game_round_controller_button_release_detect.sv
// Press-then-release qualifier: one-cycle Release pulse after a seen rising then falling edge.
module button_release_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic Button,
  output logic Release
);
  logic button_reg;
  logic armed_reg;
  logic release_reg;

  // button_reg resets high so a button held through reset never produces a rising edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      button_reg  <= 1'b1;
      armed_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      button_reg  <= Button;
      release_reg <= button_reg & ~Button & armed_reg;
      if (!button_reg && Button)
        armed_reg <= 1'b1;
      else if (button_reg && !Button)
        armed_reg <= 1'b0;
    end
  end

  assign Release = release_reg;
endmodule

// File: rtl/game_round_controller.sv
// Multi-round game sequencer with internal per-round countdown and button release qualification.
module game_round_controller
  import game_pkg::*;
#(
  parameter int ROUND_TICKS = 60,
  parameter int NUM_ROUNDS  = 3,
  parameter int TIME_W      = 8,
  parameter int ROUND_W     = 2
) (
  input logic                    Clock,
  input logic                    Reset,
  game_round_controller_if.slave bus
);
  localparam logic [TIME_W-1:0]  RELOAD    = TIME_W'(ROUND_TICKS);
  localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(NUM_ROUNDS);
  localparam logic [ROUND_W-1:0] FIRST_RND = ROUND_W'(1);

  logic [1:0] button_vec;
  logic [1:0] release_vec;
  logic       start_rel;
  logic       pause_rel;

  assign button_vec = {bus.PauseGame, bus.StartGame};
  assign start_rel  = release_vec[0];
  assign pause_rel  = release_vec[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      button_release_detect u_det (
        .Clock   (Clock),
        .Reset   (Reset),
        .Button  (button_vec[gi]),
        .Release (release_vec[gi])
      );
    end
  endgenerate

  game_state_t        state_reg;
  logic [TIME_W-1:0]  time_left_reg;
  logic [ROUND_W-1:0] round_reg;
  logic               round_done_reg;
  logic               game_done_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= GS_IDLE;
      time_left_reg  <= RELOAD;
      round_reg      <= '0;
      round_done_reg <= 1'b0;
      game_done_reg  <= 1'b0;
    end else begin
      round_done_reg <= 1'b0;
      game_done_reg  <= 1'b0;
      case (state_reg)
        GS_IDLE: begin
          // Continuous reload also clears the one-cycle TimeLeft=0 left by game over.
          time_left_reg <= RELOAD;
          round_reg     <= '0;
          if (start_rel) begin
            state_reg <= GS_PLAYING;
            round_reg <= FIRST_RND;
          end
        end
        GS_PLAYING: begin
          if (bus.Tick && time_left_reg <= TIME_W'(1)) begin
            time_left_reg  <= '0;
            round_done_reg <= 1'b1;
            if (round_reg >= LAST_RND) begin
              game_done_reg <= 1'b1;
              state_reg     <= GS_IDLE;
            end else begin
              state_reg <= GS_INTERMISSION;
            end
          end else begin
            if (bus.Tick)
              time_left_reg <= time_left_reg - TIME_W'(1);
            if (pause_rel)
              state_reg <= GS_PAUSED;
          end
        end
        GS_PAUSED: begin
          if (start_rel) begin
            state_reg     <= GS_IDLE;
            time_left_reg <= RELOAD;
            round_reg     <= '0;
          end else if (pause_rel) begin
            state_reg <= GS_PLAYING;
          end
        end
        GS_INTERMISSION: begin
          if (start_rel) begin
            state_reg     <= GS_PLAYING;
            time_left_reg <= RELOAD;
            if (round_reg < LAST_RND)
              round_reg <= round_reg + ROUND_W'(1);
          end
        end
        default: state_reg <= GS_IDLE;
      endcase
    end
  end

  assign bus.State     = state_reg;
  assign bus.TimeLeft  = time_left_reg;
  assign bus.Round     = round_reg;
  assign bus.RoundDone = round_done_reg;
  assign bus.GameDone  = game_done_reg;
endmodule

// File: tb/tb_game_round_controller.sv
// Directed scoreboard bench for game_round_controller (ROUND_TICKS=3, NUM_ROUNDS=2).
module tb_game_round_controller;
  logic clk;
  logic rst;
  int   cycle_cnt;
  int   n_tests;
  int   n_fail;

  typedef struct {
    string      name;
    int         cyc;
    logic [1:0] st;
    logic [7:0] tl;
    logic [1:0] rnd;
    logic       rd;
    logic       gd;
  } exp_t;

  exp_t sb[$];

  game_round_controller_if #(.TIME_W(8), .ROUND_W(2)) bus ();

  game_round_controller #(
    .ROUND_TICKS(3),
    .NUM_ROUNDS (2),
    .TIME_W     (8),
    .ROUND_W    (2)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Monitor: outputs are compared mid-cycle against whatever the stimulus queued.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (bus.State !== e.st || bus.TimeLeft !== e.tl || bus.Round !== e.rnd ||
          bus.RoundDone !== e.rd || bus.GameDone !== e.gd) begin
        n_fail++;
        $display("FAIL %s: got st=%0d tl=%0d rnd=%0d rd=%0d gd=%0d, expected st=%0d tl=%0d rnd=%0d rd=%0d gd=%0d",
                 e.name, bus.State, bus.TimeLeft, bus.Round, bus.RoundDone, bus.GameDone,
                 e.st, e.tl, e.rnd, e.rd, e.gd);
      end else begin
        $display("[TB] %s ok: st=%0d tl=%0d rnd=%0d rd=%0d gd=%0d",
                 e.name, e.st, e.tl, e.rnd, e.rd, e.gd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input int st, input int tl, input int rnd,
                            input int rd, input int gd);
    exp_t e;
    e.name = name;
    e.cyc  = cycle_cnt;
    e.st   = 2'(st);
    e.tl   = 8'(tl);
    e.rnd  = 2'(rnd);
    e.rd   = 1'(rd);
    e.gd   = 1'(gd);
    sb.push_back(e);
  endtask

  // which: 0=start, 1=pause, 2=both. Returns after the edge where the FSM acts.
  task automatic press_release(input int which);
    if (which != 1) bus.StartGame = 1'b1;
    if (which != 0) bus.PauseGame = 1'b1;
    cyc();
    bus.StartGame = 1'b0;
    bus.PauseGame = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic tick_once();
    bus.Tick = 1'b1;
    cyc();
    bus.Tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.StartGame = 1'b0;
    bus.PauseGame = 1'b0;
    bus.Tick      = 1'b0;
    cyc();
    cyc();
    expect_now("reset_state", 0, 3, 0, 0, 0);
    rst = 1'b0;
    cyc();
    cyc();
    expect_now("idle_after_reset", 0, 3, 0, 0, 0);
    tick_once();
    expect_now("idle_tick_ignored", 0, 3, 0, 0, 0);
    press_release(1);
    expect_now("idle_pause_ignored", 0, 3, 0, 0, 0);

    // Full game
    bus.StartGame = 1'b1;
    cyc();
    bus.StartGame = 1'b0;
    cyc();
    expect_now("start_latency", 0, 3, 0, 0, 0);
    cyc();
    expect_now("start_round1", 1, 3, 1, 0, 0);
    tick_once();
    expect_now("r1_tick1", 1, 2, 1, 0, 0);
    tick_once();
    expect_now("r1_tick2", 1, 1, 1, 0, 0);
    tick_once();
    expect_now("r1_expire", 3, 0, 1, 1, 0);
    cyc();
    expect_now("r1_pulse_end", 3, 0, 1, 0, 0);
    tick_once();
    expect_now("inter_tick_ignored", 3, 0, 1, 0, 0);
    press_release(1);
    expect_now("inter_pause_ignored", 3, 0, 1, 0, 0);
    press_release(0);
    expect_now("start_round2", 1, 3, 2, 0, 0);
    press_release(0);
    expect_now("playing_start_ignored", 1, 3, 2, 0, 0);
    tick_once();
    expect_now("r2_tick1", 1, 2, 2, 0, 0);
    tick_once();
    expect_now("r2_tick2", 1, 1, 2, 0, 0);
    tick_once();
    expect_now("game_over", 0, 0, 2, 1, 1);
    cyc();
    expect_now("game_over_reload", 0, 3, 0, 0, 0);

    // Pause, held tick, resume
    press_release(0);
    expect_now("p_start", 1, 3, 1, 0, 0);
    tick_once();
    expect_now("p_tick", 1, 2, 1, 0, 0);
    press_release(1);
    expect_now("paused", 2, 2, 1, 0, 0);
    bus.Tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_now("paused_tick_frozen", 2, 2, 1, 0, 0);
    end
    bus.Tick = 1'b0;
    press_release(1);
    expect_now("resumed", 1, 2, 1, 0, 0);

    // Abort with both releases together
    press_release(1);
    expect_now("paused_again", 2, 2, 1, 0, 0);
    press_release(2);
    expect_now("abort", 0, 3, 0, 0, 0);
    cyc();
    expect_now("abort_no_pulse", 0, 3, 0, 0, 0);

    // Expiry coinciding with the pause release event
    press_release(0);
    expect_now("s_start", 1, 3, 1, 0, 0);
    tick_once();
    tick_once();
    expect_now("s_tl1", 1, 1, 1, 0, 0);
    bus.PauseGame = 1'b1;
    cyc();
    bus.PauseGame = 1'b0;
    cyc();
    bus.Tick = 1'b1;
    cyc();
    bus.Tick = 1'b0;
    expect_now("expiry_beats_pause", 3, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_now("never_paused", 3, 0, 1, 0, 0);
    end

    // Button held through reset
    rst = 1'b1;
    bus.StartGame = 1'b1;
    cyc();
    cyc();
    expect_now("held_reset", 0, 3, 0, 0, 0);
    rst = 1'b0;
    cyc();
    cyc();
    bus.StartGame = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_now("held_release_ignored", 0, 3, 0, 0, 0);
    end
    press_release(0);
    expect_now("held_then_press", 1, 3, 1, 0, 0);

    // Reset mid-game
    tick_once();
    expect_now("mid_tick", 1, 2, 1, 0, 0);
    rst = 1'b1;
    cyc();
    expect_now("mid_reset", 0, 3, 0, 0, 0);
    rst = 1'b0;
    cyc();
    expect_now("mid_reset_after", 0, 3, 0, 0, 0);

    cyc();
    cyc();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
